// File: rtl/delta_w_batch_gen.sv
// Batched delta-weight generator: scales each sample's error by its learning rate,
// multiplies by the layer outputs LANES elements per cycle and accumulates BATCH samples.
module delta_w_batch_gen #(
    parameter int N     = 8,
    parameter int DW    = 16,
    parameter int FRAC  = 8,
    parameter int LANES = 2,
    parameter int BATCH = 4
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N*DW-1:0]              y_in,
    input  logic [DW-1:0]                d_in,
    input  logic [DW-1:0]                lr_in,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N*DW-1:0]              delta_w_out,
    output logic [$clog2(BATCH+1)-1:0]   count_out
);

    localparam int NCH = (N + LANES - 1) / LANES;
    localparam int CW  = $clog2(BATCH + 1);
    localparam int JW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [JW-1:0]           LAST_J = JW'(NCH - 1);
    localparam logic signed [DW-1:0]    SMAX   = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0]    SMIN   = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [2*DW:0]    WMAX   = {{(DW+2){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [2*DW:0]    WMIN   = {{(DW+2){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_SCALE, S_MULT, S_OUT} state_t;

    function automatic logic signed [2*DW:0] f_sext(input logic signed [DW-1:0] v);
        return {{(DW+1){v[DW-1]}}, v};
    endfunction

    function automatic logic signed [DW-1:0] f_sat(input logic signed [2*DW:0] v);
        logic signed [DW-1:0] res;
        if (v > WMAX)      res = SMAX;
        else if (v < WMIN) res = SMIN;
        else               res = v[DW-1:0];
        return res;
    endfunction

    // Fixed-point product with floor rounding, clamped back to DW bits.
    function automatic logic signed [DW-1:0] f_scale(input logic signed [DW-1:0] a,
                                                     input logic signed [DW-1:0] b);
        logic signed [2*DW:0] prod;
        prod = f_sext(a) * f_sext(b);
        return f_sat(prod >>> FRAC);
    endfunction

    function automatic logic signed [DW-1:0] f_step(input logic signed [DW-1:0] acc,
                                                    input logic signed [DW-1:0] y,
                                                    input logic signed [DW-1:0] k);
        logic signed [DW-1:0] p;
        logic signed [DW-1:0] neg;
        p   = f_scale(y, k);
        neg = (p == SMIN) ? SMAX : -p;
        return f_sat(f_sext(acc) + f_sext(neg));
    endfunction

    state_t                r_state;
    state_t                w_next;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic                  r_flush_pending;
    logic [CW-1:0]         r_count;
    logic [JW-1:0]         r_j;
    logic signed [DW-1:0]  r_k;
    logic signed [DW-1:0]  r_d;
    logic signed [DW-1:0]  r_lr;
    logic signed [DW-1:0]  r_y   [N];
    logic signed [DW-1:0]  r_acc [N];
    logic signed [DW-1:0]  w_lane_y   [LANES];
    logic signed [DW-1:0]  w_lane_acc [LANES];
    logic signed [DW-1:0]  w_lane_new [LANES];

    logic          w_accept;
    logic          w_hs;
    logic          w_fp;
    logic          w_last;
    logic [CW-1:0] w_cnt_inc;

    assign w_accept  = (r_state == S_IDLE) && r_in_ready && in_valid;
    assign w_hs      = (r_state == S_OUT) && r_out_valid && out_ready;
    assign w_fp      = r_flush_pending | flush;
    assign w_last    = (r_j == LAST_J);
    assign w_cnt_inc = r_count + CW'(1);

    // Route the current chunk of elements onto the shared multiplier lanes.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_lane_y[l]   = '0;
            w_lane_acc[l] = '0;
        end
        for (int i = 0; i < N; i++) begin
            w_lane_y[i % LANES]   = (int'(r_j) == i / LANES) ? r_y[i]   : w_lane_y[i % LANES];
            w_lane_acc[i % LANES] = (int'(r_j) == i / LANES) ? r_acc[i] : w_lane_acc[i % LANES];
        end
        for (int l = 0; l < LANES; l++) begin
            w_lane_new[l] = f_step(w_lane_acc[l], w_lane_y[l], r_k);
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (w_accept)                         w_next = S_SCALE;
                else if (w_fp && (r_count != '0))     w_next = S_OUT;
                else                                  w_next = S_IDLE;
            end
            S_SCALE: w_next = S_MULT;
            S_MULT: begin
                if (!w_last)                                   w_next = S_MULT;
                else if ((w_cnt_inc == CW'(BATCH)) || w_fp)    w_next = S_OUT;
                else                                           w_next = S_IDLE;
            end
            S_OUT: begin
                if (w_hs) w_next = S_IDLE;
                else      w_next = S_OUT;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Control state; handshake flags follow the state with one cycle of lag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state         <= S_IDLE;
            r_in_ready      <= 1'b0;
            r_out_valid     <= 1'b0;
            r_flush_pending <= 1'b0;
            r_count         <= '0;
            r_j             <= '0;
            r_k             <= '0;
        end else begin
            r_state     <= w_next;
            r_in_ready  <= (r_state == S_IDLE) && (w_next == S_IDLE);
            r_out_valid <= (r_state == S_OUT) && (w_next == S_OUT);
            if (w_hs)
                r_flush_pending <= 1'b0;
            else if ((r_state == S_IDLE) && !w_accept && (r_count == '0))
                r_flush_pending <= 1'b0;
            else if (flush)
                r_flush_pending <= 1'b1;
            if (w_hs)
                r_count <= '0;
            else if ((r_state == S_MULT) && w_last)
                r_count <= w_cnt_inc;
            if (r_state == S_MULT)
                r_j <= w_last ? '0 : r_j + JW'(1);
            else
                r_j <= '0;
            if (r_state == S_SCALE)
                r_k <= f_scale(r_d, r_lr);
        end
    end

    // Sample capture.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_d  <= '0;
            r_lr <= '0;
            for (int i = 0; i < N; i++) r_y[i] <= '0;
        end else if (w_accept) begin
            r_d  <= d_in;
            r_lr <= lr_in;
            for (int i = 0; i < N; i++) r_y[i] <= y_in[i*DW +: DW];
        end
    end

    // Accumulators: one chunk per MULT cycle, cleared when the update is taken.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < N; i++) r_acc[i] <= '0;
        end else if (w_hs) begin
            for (int i = 0; i < N; i++) r_acc[i] <= '0;
        end else if (r_state == S_MULT) begin
            for (int i = 0; i < N; i++) begin
                if (int'(r_j) == i / LANES) r_acc[i] <= w_lane_new[i % LANES];
            end
        end
    end

    genvar g;
    for (g = 0; g < N; g++) begin : g_pack
        assign delta_w_out[g*DW +: DW] = r_acc[g];
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign count_out = r_count;

endmodule

// File: doc/delta_w_batch_gen.md
DELTA_W_BATCH_GEN -- requirements
Module: delta_w_batch_gen

Interface
REQ-001 Parameter N, default 8: weight-vector element count; N >= 1.
REQ-002 Parameter DW, default 16: signed two's-complement element width.
REQ-003 Parameter FRAC, default 8: fractional bits of every operand and result; 0 <= FRAC < DW.
REQ-004 Parameter LANES, default 2: multipliers used per MULT cycle; 1 <= LANES <= N.
REQ-005 Parameter BATCH, default 4: samples accumulated per output; BATCH >= 1.
REQ-006 Clocking: one clock; reset is asynchronous and active-low.
REQ-007 CLK  in  1  rising-edge system clock.
REQ-008 RST_N  in  1  asynchronous active-low reset.
REQ-009 in_valid  in  1  sample offered.
REQ-010 in_ready  out  1  block can accept a sample.
REQ-011 y_in  in  N*DW  layer outputs; element i is bits [i*DW +: DW].
REQ-012 d_in  in  DW  error/delta term for the sample.
REQ-013 lr_in  in  DW  learning rate for the sample.
REQ-014 flush  in  1  single-cycle request to emit a partial batch.
REQ-015 out_valid  out  1  accumulated weight update available.
REQ-016 out_ready  in  1  consumer takes the update.
REQ-017 delta_w_out  out  N*DW  accumulated update, same packing as y_in.
REQ-018 count_out  out  clog2(BATCH+1)  samples contained in the current or presented accumulation.

Function
REQ-019 FSM states: IDLE, SCALE, MULT, OUT; every other encoding recovers to IDLE.
REQ-020 IDLE: in_ready=1; in_valid=1 captures y_in, d_in and lr_in into registers, then SCALE.
REQ-021 SCALE, one cycle: k = sat(asr(d*lr, FRAC)).
  - asr = arithmetic shift right (floor).
  - sat = clamp to [-2^(DW-1), 2^(DW-1)-1].
REQ-022 MULT, ceil(N/LANES) cycles: each cycle processes elements j*LANES .. min(N, (j+1)*LANES)-1.
  - p = sat(asr(y[i]*k, FRAC)); delta = sat(-p), so -min maps to max.
  - acc[i] <= sat(acc[i] + delta), computed at DW+1 bits.
REQ-023 End of MULT, count increments:
  - count == BATCH, or flush pending -> OUT.
  - Otherwise -> IDLE.
REQ-024 OUT: out_valid=1; delta_w_out and count_out hold stable until out_valid && out_ready.
  - On that handshake: acc cleared to 0, count cleared to 0, flush_pending cleared, then IDLE.
REQ-025 in_ready is 0 in SCALE, MULT and OUT; inputs are ignored while in_ready is 0.
REQ-026 flush asserted in any state sets flush_pending.
REQ-027 In IDLE with flush_pending, count > 0 and in_valid=0 -> OUT next cycle.
REQ-028 In IDLE with flush_pending and count == 0 -> flush_pending cleared, state stays IDLE, no output.
REQ-029 In IDLE, in_valid and flush both asserted: the sample is accepted and the output follows after its MULT.
REQ-030 Sample latency: accept edge t; out_valid at t + 2 + ceil(N/LANES) when the batch closes.
  - Back-to-back samples cost 2 + ceil(N/LANES) + 1 cycles each.
REQ-031 delta_w_out is driven from the acc registers in every state; it is meaningful only while out_valid=1.
REQ-032 All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

Reset
REQ-033 RST_N low, asynchronous: state=IDLE, acc=0, count=0, flush_pending=0, out_valid=0, delta_w_out=0, count_out=0.
  - in_ready=1 after the first clock following reset release.
REQ-034 Reset mid-MULT or mid-OUT discards the partial accumulation; no out_valid pulse follows.

Verification
Bench parameters: N=4, DW=16, FRAC=8, LANES=2, BATCH=2.
REQ-035 Two samples, d=256, lr=128, y={256,512,-256,0}, out_ready=1.
  - Required: out_valid 4 cycles after the second accept.
  - Required: delta_w_out={-256,-512,256,0}, count_out=2.
REQ-036 Saturation: d=32767, lr=32767, y={32767,-32768,1,0}, BATCH=2.
  - Required: delta_w_out={-32768,32767,-254,0}.
REQ-037 One sample, then flush with no further input.
  - Required: OUT with count_out=1 and the single-sample values.
  - Required: flush with count=0 produces no out_valid.
REQ-038 Backpressure: out_ready=0 for 10 cycles while out_valid=1.
  - Required: outputs stable, in_ready=0, in_valid pulses ignored; on release, handshake completes and acc reads 0 next batch.
REQ-039 Reset: RST_N dropped during MULT of the second sample.
  - Required: outputs 0, IDLE.
  - Required: the next two samples give a result unaffected by pre-reset data.
